// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: state
// encodings, RV32I major opcodes, datapath select encodings, the opcode
// class produced by mc_opcode_class, and the bundled control-strobe payload.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned SEL_W    = 2;

  // Instruction phases; encodings 5..7 are illegal and recover to ST_IF.
  typedef enum logic [STATE_W-1:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4
  } state_e;

  localparam state_e RESET_STATE = ST_IF;

  // RV32I major opcodes (IR[6:0]).
  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_ECALL  = 7'b1110011;

  // Next-PC source mux.
  typedef enum logic [SEL_W-1:0] {
    PCS_PC4 = 2'd0,
    PCS_ALU = 2'd1,
    PCS_BR  = 2'd2
  } pc_source_e;

  // Register-file write-data mux.
  typedef enum logic [SEL_W-1:0] {
    WB_ALU = 2'd0,
    WB_MDR = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  // ALU operand B mux.
  typedef enum logic [SEL_W-1:0] {
    ASB_RS2  = 2'd0,
    ASB_IMM  = 2'd1,
    ASB_FOUR = 2'd2
  } alu_src_b_e;

  // ALU operation class.
  typedef enum logic [SEL_W-1:0] {
    AOP_ADD   = 2'd0,
    AOP_BR    = 2'd1,
    AOP_FUNCT = 2'd2
  } alu_op_e;

  // ALU operand A mux.
  localparam logic ASA_PC  = 1'b0;
  localparam logic ASA_RS1 = 1'b1;

  // Memory address mux.
  localparam logic IORD_PC  = 1'b0;
  localparam logic IORD_ALU = 1'b1;

  // Decoded instruction class.
  typedef enum logic [3:0] {
    CLS_R       = 4'd0,
    CLS_I       = 4'd1,
    CLS_LD      = 4'd2,
    CLS_ST      = 4'd3,
    CLS_BR      = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_ECALL   = 4'd7,
    CLS_ILLEGAL = 4'd8
  } op_class_e;

  // Every datapath strobe and select driven by the control unit.
  typedef struct packed {
    logic             pc_write;
    logic [SEL_W-1:0] pc_source;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;
    logic [SEL_W-1:0] wb_sel;
    logic             alu_src_a;
    logic [SEL_W-1:0] alu_src_b;
    logic [SEL_W-1:0] alu_op;
    logic             is_ecall;
  } ctrl_t;

  // All strobes low, all selects at encoding 0.
  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/mc_opcode_class.sv
// Combinational RV32I opcode classifier.
// Ports:
//   i_opcode   - IR[6:0]
//   o_op_class - instruction class; anything unrecognised is CLS_ILLEGAL
module mc_opcode_class
  import mc_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] i_opcode,
  output op_class_e           o_op_class
);

  always_comb begin
    o_op_class = CLS_ILLEGAL;
    case (i_opcode)
      OP_R:      o_op_class = CLS_R;
      OP_I:      o_op_class = CLS_I;
      OP_LOAD:   o_op_class = CLS_LD;
      OP_STORE:  o_op_class = CLS_ST;
      OP_BRANCH: o_op_class = CLS_BR;
      OP_JAL:    o_op_class = CLS_JAL;
      OP_JALR:   o_op_class = CLS_JALR;
      OP_ECALL:  o_op_class = CLS_ECALL;
      default:   o_op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle RV32I core. Sequences each instruction
// through IF/ID/EX/MEM/WB and drives every datapath strobe, including the
// PC write enable (asserted only in an instruction's final cycle).
// Ports:
//   clk, reset (async, active-low)
//   opcode, bcond, mem_ready        - IR opcode, branch compare, memory done
//   pc_write, pc_source             - PC load enable and next-PC select
//   i_or_d, mem_read, mem_write     - memory address select and requests
//   ir_write, reg_write, wb_sel     - IR/MDR capture, regfile write and data
//   alu_src_a, alu_src_b, alu_op    - ALU operand/op selects
//   is_ecall                        - ECALL seen in ID
//   state                           - current state (debug)
// Outputs are combinational from state/opcode/bcond/mem_ready and are
// forced to zero while reset is held.
module multicycle_control
  import mc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                bcond,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic [SEL_W-1:0]    pc_source,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic [SEL_W-1:0]    wb_sel,
  output logic                alu_src_a,
  output logic [SEL_W-1:0]    alu_src_b,
  output logic [SEL_W-1:0]    alu_op,
  output logic                is_ecall,
  output logic [STATE_W-1:0]  state
);

  state_e    r_state;
  state_e    w_next_state;
  op_class_e w_class;
  ctrl_t     w_ctrl;
  ctrl_t     w_out;

  mc_opcode_class u_opcode_class (
    .i_opcode   (opcode),
    .o_op_class (w_class)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_ctrl       = CTRL_IDLE;
    w_next_state = r_state;

    case (r_state)
      ST_IF: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = IORD_PC;
        if (mem_ready) begin
          w_ctrl.ir_write = 1'b1;
          w_next_state    = ST_ID;
        end
      end

      ST_ID: begin
        // Precompute PC+imm into ALUOut for a possible branch.
        w_ctrl.alu_src_a = ASA_PC;
        w_ctrl.alu_src_b = ASB_IMM;
        w_ctrl.alu_op    = AOP_ADD;
        case (w_class)
          CLS_ECALL: begin
            w_ctrl.is_ecall  = 1'b1;
            w_ctrl.pc_write  = 1'b1;
            w_ctrl.pc_source = PCS_PC4;
            w_next_state     = ST_IF;
          end
          CLS_ILLEGAL: begin
            w_ctrl.pc_write  = 1'b1;
            w_ctrl.pc_source = PCS_PC4;
            w_next_state     = ST_IF;
          end
          default: w_next_state = ST_EX;
        endcase
      end

      ST_EX: begin
        case (w_class)
          CLS_R: begin
            w_ctrl.alu_src_a = ASA_RS1;
            w_ctrl.alu_src_b = ASB_RS2;
            w_ctrl.alu_op    = AOP_FUNCT;
            w_next_state     = ST_WB;
          end
          CLS_I: begin
            w_ctrl.alu_src_a = ASA_RS1;
            w_ctrl.alu_src_b = ASB_IMM;
            w_ctrl.alu_op    = AOP_FUNCT;
            w_next_state     = ST_WB;
          end
          CLS_LD, CLS_ST: begin
            w_ctrl.alu_src_a = ASA_RS1;
            w_ctrl.alu_src_b = ASB_IMM;
            w_ctrl.alu_op    = AOP_ADD;
            w_next_state     = ST_MEM;
          end
          CLS_BR: begin
            // ALUOut already holds PC+imm from ID; the ALU now compares.
            w_ctrl.alu_src_a = ASA_RS1;
            w_ctrl.alu_src_b = ASB_RS2;
            w_ctrl.alu_op    = AOP_BR;
            w_ctrl.pc_write  = 1'b1;
            w_ctrl.pc_source = bcond ? PCS_BR : PCS_PC4;
            w_next_state     = ST_IF;
          end
          CLS_JAL, CLS_JALR: begin
            // rd <= PC+4 and PC <= target share one edge, both from old PC.
            w_ctrl.alu_src_a = (w_class == CLS_JALR) ? ASA_RS1 : ASA_PC;
            w_ctrl.alu_src_b = ASB_IMM;
            w_ctrl.alu_op    = AOP_ADD;
            w_ctrl.pc_write  = 1'b1;
            w_ctrl.pc_source = PCS_ALU;
            w_ctrl.reg_write = 1'b1;
            w_ctrl.wb_sel    = WB_PC4;
            w_next_state     = ST_IF;
          end
          default: w_next_state = ST_IF;
        endcase
      end

      ST_MEM: begin
        w_ctrl.i_or_d = IORD_ALU;
        case (w_class)
          CLS_LD: begin
            w_ctrl.mem_read = 1'b1;
            if (mem_ready) begin
              w_ctrl.ir_write = 1'b1;
              w_next_state    = ST_WB;
            end
          end
          CLS_ST: begin
            w_ctrl.mem_write = 1'b1;
            if (mem_ready) begin
              w_ctrl.pc_write  = 1'b1;
              w_ctrl.pc_source = PCS_PC4;
              w_next_state     = ST_IF;
            end
          end
          default: w_next_state = ST_IF;
        endcase
      end

      ST_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCS_PC4;
        w_ctrl.wb_sel    = (w_class == CLS_LD) ? WB_MDR : WB_ALU;
        w_next_state     = ST_IF;
      end

      // Illegal encodings: all strobes low, recover to IF.
      default: w_next_state = ST_IF;
    endcase
  end

  // Reset masks the IF request that the reset state would otherwise drive.
  assign w_out = reset ? w_ctrl : CTRL_IDLE;

  assign pc_write  = w_out.pc_write;
  assign pc_source = w_out.pc_source;
  assign i_or_d    = w_out.i_or_d;
  assign mem_read  = w_out.mem_read;
  assign mem_write = w_out.mem_write;
  assign ir_write  = w_out.ir_write;
  assign reg_write = w_out.reg_write;
  assign wb_sel    = w_out.wb_sel;
  assign alu_src_a = w_out.alu_src_a;
  assign alu_src_b = w_out.alu_src_b;
  assign alu_op    = w_out.alu_op;
  assign is_ecall  = w_out.is_ecall;
  assign state     = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: every cycle the full output vector
// is compared against a hand-built expected vector.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [6:0] opcode;
  logic       bcond;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       is_ecall;
  logic [2:0] state;

  int errors;
  int checks;

  multicycle_control dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .bcond     (bcond),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .pc_source (pc_source),
    .i_or_d    (i_or_d),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .ir_write  (ir_write),
    .reg_write (reg_write),
    .wb_sel    (wb_sel),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_op    (alu_op),
    .is_ecall  (is_ecall),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
  //  reg_write, wb_sel, alu_src_a, alu_src_b, alu_op, is_ecall}
  logic [18:0] w_obs;
  assign w_obs = {state, pc_write, pc_source, i_or_d, mem_read, mem_write,
                  ir_write, reg_write, wb_sel, alu_src_a, alu_src_b, alu_op,
                  is_ecall};

  function automatic logic [18:0] ev(
    input logic [2:0] st, input logic pcw, input logic [1:0] pcs,
    input logic iord, input logic mr, input logic mw, input logic irw,
    input logic rw, input logic [1:0] wbs, input logic asa,
    input logic [1:0] asb, input logic [1:0] aop, input logic ec);
    return {st, pcw, pcs, iord, mr, mw, irw, rw, wbs, asa, asb, aop, ec};
  endfunction

  task automatic chk(input string tag, input logic [18:0] exp);
    checks++;
    assert (w_obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%05h expected=%05h", tag, w_obs, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, advance past the edge.
  task automatic cyc(input logic mr, input logic bc, input logic [18:0] exp,
                     input string tag);
    mem_ready = mr;
    bcond     = bc;
    #1;
    chk(tag, exp);
    @(posedge clk);
    #1;
  endtask

  logic [18:0] E_ZERO, E_IF_W, E_IF_R, E_ID, E_ID_EC, E_ID_NOP;
  logic [18:0] E_EX_R, E_EX_I, E_EX_LS, E_EX_BT, E_EX_BN, E_EX_JAL, E_EX_JALR;
  logic [18:0] E_MEM_LW, E_MEM_LR, E_MEM_SW, E_MEM_SR, E_WB_R, E_WB_LD;

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    //          st   pcw pcs  iod mr  mw  irw rw  wbs  asa asb  aop  ec
    E_ZERO    = ev(3'd0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0);
    E_IF_W    = ev(3'd0, 0, 2'd0, 0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0);
    E_IF_R    = ev(3'd0, 0, 2'd0, 0, 1, 0, 1, 0, 2'd0, 0, 2'd0, 2'd0, 0);
    E_ID      = ev(3'd1, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, 0);
    E_ID_EC   = ev(3'd1, 1, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, 1);
    E_ID_NOP  = ev(3'd1, 1, 2'd0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, 2'd0, 0);
    E_EX_R    = ev(3'd2, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd2, 0);
    E_EX_I    = ev(3'd2, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd2, 0);
    E_EX_LS   = ev(3'd2, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd1, 2'd0, 0);
    E_EX_BT   = ev(3'd2, 1, 2'd2, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd1, 0);
    E_EX_BN   = ev(3'd2, 1, 2'd0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, 2'd1, 0);
    E_EX_JAL  = ev(3'd2, 1, 2'd1, 0, 0, 0, 0, 1, 2'd2, 0, 2'd1, 2'd0, 0);
    E_EX_JALR = ev(3'd2, 1, 2'd1, 0, 0, 0, 0, 1, 2'd2, 1, 2'd1, 2'd0, 0);
    E_MEM_LW  = ev(3'd3, 0, 2'd0, 1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0);
    E_MEM_LR  = ev(3'd3, 0, 2'd0, 1, 1, 0, 1, 0, 2'd0, 0, 2'd0, 2'd0, 0);
    E_MEM_SW  = ev(3'd3, 0, 2'd0, 1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0);
    E_MEM_SR  = ev(3'd3, 1, 2'd0, 1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0);
    E_WB_R    = ev(3'd4, 1, 2'd0, 0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 2'd0, 0);
    E_WB_LD   = ev(3'd4, 1, 2'd0, 0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 2'd0, 0);

    // Power-on reset: everything zero, even with mem_ready high.
    reset     = 1'b0;
    opcode    = 7'b0110011;
    bcond     = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("por", E_ZERO);
    @(posedge clk);
    #1;
    chk("por_held", E_ZERO);
    reset = 1'b1;

    // ADD, zero wait states: IF ID EX WB.
    opcode = 7'b0110011;
    cyc(1, 0, E_IF_R, "add_if");
    cyc(1, 0, E_ID,   "add_id");
    cyc(1, 0, E_EX_R, "add_ex");
    cyc(1, 0, E_WB_R, "add_wb");

    // R-type aborted by reset in EX, held 2 cycles.
    cyc(1, 0, E_IF_R, "abort_if");
    cyc(1, 0, E_ID,   "abort_id");
    mem_ready = 1'b1;
    #1;
    chk("abort_ex", E_EX_R);
    reset = 1'b0;
    #1;
    chk("rst_async", E_ZERO);
    @(posedge clk);
    #1;
    chk("rst_hold1", E_ZERO);
    @(posedge clk);
    #1;
    chk("rst_hold2", E_ZERO);
    reset = 1'b1;
    cyc(0, 0, E_IF_W, "post_rel_if");

    // Same ADD resumes from IF after the stall cycle.
    cyc(1, 0, E_IF_R, "add2_if");
    cyc(1, 0, E_ID,   "add2_id");
    cyc(1, 0, E_EX_R, "add2_ex");
    cyc(1, 0, E_WB_R, "add2_wb");

    // LW: 2 IF stalls, 3 MEM stalls -> 10 cycles.
    opcode = 7'b0000011;
    cyc(0, 0, E_IF_W,   "lw_if_w1");
    cyc(0, 0, E_IF_W,   "lw_if_w2");
    cyc(1, 0, E_IF_R,   "lw_if_r");
    cyc(1, 0, E_ID,     "lw_id");
    cyc(1, 0, E_EX_LS,  "lw_ex");
    cyc(0, 0, E_MEM_LW, "lw_mem_w1");
    cyc(0, 0, E_MEM_LW, "lw_mem_w2");
    cyc(0, 0, E_MEM_LW, "lw_mem_w3");
    cyc(1, 0, E_MEM_LR, "lw_mem_r");
    cyc(1, 0, E_WB_LD,  "lw_wb");

    // BEQ taken then not taken.
    opcode = 7'b1100011;
    cyc(1, 0, E_IF_R,  "beq_t_if");
    cyc(1, 0, E_ID,    "beq_t_id");
    cyc(1, 1, E_EX_BT, "beq_t_ex");
    cyc(1, 0, E_IF_R,  "beq_n_if");
    cyc(1, 0, E_ID,    "beq_n_id");
    cyc(1, 0, E_EX_BN, "beq_n_ex");

    // JAL and JALR.
    opcode = 7'b1101111;
    cyc(1, 0, E_IF_R,   "jal_if");
    cyc(1, 0, E_ID,     "jal_id");
    cyc(1, 0, E_EX_JAL, "jal_ex");
    opcode = 7'b1100111;
    cyc(1, 0, E_IF_R,    "jalr_if");
    cyc(1, 0, E_ID,      "jalr_id");
    cyc(1, 0, E_EX_JALR, "jalr_ex");

    // ECALL and illegal opcode: 2 cycles each.
    opcode = 7'b1110011;
    cyc(1, 0, E_IF_R,  "ecall_if");
    cyc(1, 0, E_ID_EC, "ecall_id");
    opcode = 7'b1111111;
    cyc(1, 0, E_IF_R,   "ill_if");
    cyc(1, 0, E_ID_NOP, "ill_id");

    // ADDI with mem_ready low outside IF/MEM: must not stall.
    opcode = 7'b0010011;
    cyc(1, 1, E_IF_R, "addi_if");
    cyc(0, 1, E_ID,   "addi_id");
    cyc(0, 1, E_EX_I, "addi_ex");
    cyc(0, 1, E_WB_R, "addi_wb");

    // SW with one MEM stall.
    opcode = 7'b0100011;
    cyc(1, 0, E_IF_R,   "sw_if");
    cyc(1, 0, E_ID,     "sw_id");
    cyc(1, 0, E_EX_LS,  "sw_ex");
    cyc(0, 0, E_MEM_SW, "sw_mem_w");
    cyc(1, 0, E_MEM_SR, "sw_mem_r");

    // Back in IF after the store.
    mem_ready = 1'b0;
    #1;
    chk("final_if", E_IF_W);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Control state machine for the multi-cycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath strobe, including the `pc_write` enable consumed by the program-counter register, so that register never decides on its own when to advance. It sits between the instruction register/ALU flags and all datapath muxes, register file and memory port.

## Interface
- `RESET_STATE`, `ST_IF`: state entered on reset.
- `clk` in, 1: single clock. All state changes happen on the rising edge.
- `reset` in, 1: asynchronous, active-low. `reset`=0 clears state immediately.
- `opcode` in, 7: IR[6:0]. Stable from ID until the next IF completes.
- `bcond` in, 1: ALU branch-compare result. Valid during EX of a branch.
- `mem_ready` in, 1: memory completes the current access at this rising edge.
- `pc_write` out, 1: PC loads `next_pc` at the next edge.
- `pc_source` out, 2: 0 = PC+4 adder, 1 = ALU result, 2 = branch target (PC+imm).
- `i_or_d` out, 1: memory address. 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` out, 1 each: memory request strobes.
- `ir_write` out, 1: IR and MDR capture.
- `reg_write` out, 1: register-file write enable.
- `wb_sel` out, 2: 0 = ALUOut, 1 = MDR, 2 = PC+4.
- `alu_src_a` out, 1: 0 = PC, 1 = rs1.
- `alu_src_b` out, 2: 0 = rs2, 1 = imm, 2 = constant 4.
- `alu_op` out, 2: 0 = ADD, 1 = branch compare, 2 = funct-decoded.
- `is_ecall` out, 1: ECALL seen in ID. Used by the halt logic.
- `state` out, 3: current state, for debug and the bench.

## Operation
- The states are IF, ID, EX, MEM and WB, encoded 0 to 4. Encodings 5 to 7 are illegal and go to IF on the next edge with all strobes 0.
- Outputs are combinational from `state`, `opcode`, `bcond` and `mem_ready`. Any strobe not listed for a state is 0. Mux selects not listed for a state are don't-care; drive them 0.
- **IF**
  - Drives `mem_read`=1 and `i_or_d`=0.
  - Holds while `mem_ready`=0.
  - When `mem_ready`=1: drives `ir_write`=1 and moves to ID.
- **ID**
  - Drives `alu_src_a`=0, `alu_src_b`=1, `alu_op`=0, so ALUOut receives the branch/jump base.
  - ECALL (1110011): drives `is_ecall`=1, `pc_write`=1, `pc_source`=0, then goes to IF.
  - Unknown opcode: acts as a NOP. Drives `pc_write`=1, `pc_source`=0, then goes to IF.
  - All other opcodes go to EX.
- **EX**
  - R-type (0110011): `alu_src_a`=1, `alu_src_b`=0, `alu_op`=2, then WB.
  - I-arith (0010011): `alu_src_a`=1, `alu_src_b`=1, `alu_op`=2, then WB.
  - LOAD (0000011) and STORE (0100011): `alu_src_a`=1, `alu_src_b`=1, `alu_op`=0, then MEM.
  - BRANCH (1100011): `alu_src_a`=1, `alu_src_b`=0, `alu_op`=1, `pc_write`=1, `pc_source` = `bcond` ? 2 : 0, then IF.
  - JAL (1101111): `alu_src_a`=0, `alu_src_b`=1, `alu_op`=0, `pc_write`=1, `pc_source`=1, `reg_write`=1, `wb_sel`=2, then IF.
  - JALR (1100111): same as JAL except `alu_src_a`=1. The PC and rd updates happen at the same edge and both use the old PC.
- **MEM**
  - Drives `i_or_d`=1.
  - LOAD: `mem_read`=1. When `mem_ready`=1: `ir_write`=1 (MDR capture), then WB.
  - STORE: `mem_write`=1. When `mem_ready`=1: `pc_write`=1, `pc_source`=0, then IF.
  - Holds while `mem_ready`=0.
- **WB**
  - Drives `reg_write`=1, `pc_write`=1, `pc_source`=0, then IF.
  - `wb_sel` = 1 for LOAD, otherwise 0.
- `pc_write` is asserted in exactly one cycle per instruction. That cycle is the instruction's final cycle.

## Timing
- `reset`=0 forces `state`=IF asynchronously. While `reset`=0, every strobe is 0: `pc_write`, `ir_write`, `reg_write`, `mem_read`, `mem_write`, `is_ecall`. All selects are also 0.
- The first IF request appears in the first cycle after `reset` rises. Reset asserted mid-instruction abandons it: no further `pc_write` or `reg_write`.
- Cycle counts with `mem_ready` held at 1:
  - 2 cycles: ECALL, NOP.
  - 3 cycles: BRANCH, JAL, JALR.
  - 4 cycles: R-type, I-arith, STORE.
  - 5 cycles: LOAD.
- Each cycle with `mem_ready`=0 in IF or MEM adds one cycle.
- Memory handshake:
  - A request is held until `mem_ready`=1.
  - The write commits at that edge.
  - `mem_ready` is ignored outside IF and MEM.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state encodings ST_IF to ST_WB;
  - RV32I opcode constants;
  - `pc_source`, `wb_sel`, `alu_src_b` and `alu_op` encodings.
- One sub-module, `mc_opcode_class`: combinational opcode-to-class decode (R, I, LD, ST, BR, JAL, JALR, ECALL, ILLEGAL) used by the next-state and output logic.

## Test plan
- **Reset and stall**
  - Stimulus: assert `reset`=0 in EX of an R-type, hold 2 cycles, release.
  - Required: `state`=IF immediately. All strobes 0 during reset. `mem_read`=1 in the first cycle after release.
- **ADD, zero wait states**
  - Stimulus: `opcode`=0110011, `mem_ready`=1.
  - Required: states IF, ID, EX, WB. `reg_write`=1 with `wb_sel`=0 in cycle 4. `pc_write`=1 only in cycle 4.
- **LW with memory stalls**
  - Stimulus: `opcode`=0000011, `mem_ready` low 2 cycles in IF and 3 cycles in MEM.
  - Required: 10 cycles in total. `wb_sel`=1. `pc_write` asserted once.
- **BEQ taken and not taken**
  - Stimulus: `opcode`=1100011 with `bcond`=1, then with `bcond`=0.
  - Required: `pc_source`=2 for taken, 0 for not taken, in EX. Back in IF after 3 cycles. `reg_write` never asserted.
- **JAL**
  - Stimulus: `opcode`=1101111.
  - Required: in EX, `pc_write`=1, `pc_source`=1, `reg_write`=1 and `wb_sel`=2 in the same cycle.
- **ECALL and illegal opcode**
  - Stimulus: `opcode`=1110011, then `opcode`=1111111.
  - Required: both take 2 cycles. `is_ecall`=1 only for 1110011. `pc_source`=0 for both.
